id_decode_stage: RTL and testbench

IF/ID pipeline stage that registers fetched instructions, classifies the opcode, and presents the immediate field and immediate-type select to the `ImmGen` in EX. It sits between instruction fetch and EX. It uses a valid/ready handshake with a 2-entry skid buffer, so a stall in EX never drops or duplicates an instruction. A branch/jump flush squashes all in-flight entries.

---
 rtl/id_decode_if.sv | 30 +++
 rtl/id_decode_stage.sv | 88 ++++++++
 tb/tb_id_decode_stage.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/id_decode_if.sv
// id_decode_if: fetch-to-EX handshake and decoded-field bundle for id_decode_stage
// master: fetch/EX side (drives if_*, flush, ex_ready); slave: the decode stage (drives if_ready and id_*).
interface id_decode_if #(
    parameter int XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_inst;
    logic [XLEN-1:0] if_pc;
    logic            flush;
    logic            ex_ready;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [24:0]     id_imm;
    logic [4:0]      id_SextOpe;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [6:0]      id_opcode;
    logic            id_illegal;

    modport master (
        output if_valid, if_inst, if_pc, flush, ex_ready,
        input  if_ready, id_valid, id_pc, id_imm, id_SextOpe, id_rs1, id_rs2, id_rd, id_opcode, id_illegal
    );
    modport slave (
        input  if_valid, if_inst, if_pc, flush, ex_ready,
        output if_ready, id_valid, id_pc, id_imm, id_SextOpe, id_rs1, id_rs2, id_rd, id_opcode, id_illegal
    );
endinterface

// File: rtl/id_decode_stage.sv
// id_decode_stage: IF/ID register stage with a 2-entry skid buffer and opcode / immediate-type decode
// Ports: clk; rst_n (synchronous, active-low); bus (id_decode_if.slave) carrying the fetch handshake
// (if_valid/if_ready/if_inst/if_pc), flush, the EX handshake (id_valid/ex_ready) and the decoded fields.
// Immediate-type codes are one-hot: I=00001, S=00010, B=00100, J=01000, U=10000, none=00000.
module id_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    id_decode_if.slave bus
);
    localparam logic [4:0] IMM_I = 5'b00001;
    localparam logic [4:0] IMM_S = 5'b00010;
    localparam logic [4:0] IMM_B = 5'b00100;
    localparam logic [4:0] IMM_J = 5'b01000;
    localparam logic [4:0] IMM_U = 5'b10000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      sext;
        logic            illegal;
    } entry_t;

    entry_t     main_q, skid_q, new_e;
    logic       main_valid, skid_valid, ready_q, accept, transfer;
    logic [6:0] op;

    // Decode happens on the incoming word so both storage slots hold finished entries.
    always_comb begin
        op          = bus.if_inst[6:0];
        new_e.pc    = bus.if_pc;
        new_e.inst  = bus.if_inst;
        new_e.sext  = (op == 7'b0000011 || op == 7'b0010011 || op == 7'b1100111 || op == 7'b1110011) ? IMM_I :
                      (op == 7'b0100011) ? IMM_S :
                      (op == 7'b1100011) ? IMM_B :
                      (op == 7'b1101111) ? IMM_J :
                      (op == 7'b0110111 || op == 7'b0010111) ? IMM_U : 5'b00000;
        // R-type is the only legal opcode without an immediate.
        new_e.illegal = (new_e.sext == 5'b00000) && (op != 7'b0110011);
    end

    assign accept   = bus.if_valid && ready_q;
    assign transfer = main_valid && bus.ex_ready;

    // ready_q mirrors !skid_valid so if_ready comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (bus.flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
        end else if (skid_valid) begin
            if (transfer) begin
                main_q     <= skid_q;
                skid_valid <= 1'b0;
                ready_q    <= 1'b1;
            end
        end else if (accept) begin
            if (!main_valid || transfer) begin
                main_q     <= new_e;
                main_valid <= 1'b1;
            end else begin
                skid_q     <= new_e;
                skid_valid <= 1'b1;
                ready_q    <= 1'b0;
            end
        end else if (transfer) begin
            main_valid <= 1'b0;
        end
    end

    assign bus.if_ready   = ready_q;
    assign bus.id_valid   = main_valid;
    assign bus.id_pc      = main_q.pc;
    assign bus.id_imm     = main_q.inst[31:7];
    assign bus.id_SextOpe = main_q.sext;
    assign bus.id_rs1     = main_q.inst[19:15];
    assign bus.id_rs2     = main_q.inst[24:20];
    assign bus.id_rd      = main_q.inst[11:7];
    assign bus.id_opcode  = main_q.inst[6:0];
    assign bus.id_illegal = main_q.illegal;
endmodule

// File: tb/tb_id_decode_stage.sv
// tb_id_decode_stage: directed checks of reset, decode, stall, flush, illegal and reset-while-full behaviour
module tb_id_decode_stage;
    localparam logic [4:0] IMM_I = 5'b00001;
    localparam logic [4:0] IMM_S = 5'b00010;
    localparam logic [4:0] IMM_B = 5'b00100;
    localparam logic [4:0] IMM_J = 5'b01000;
    localparam logic [4:0] IMM_U = 5'b10000;

    logic clk, rst_n;
    int   vectors, miscompares;

    id_decode_if #(.XLEN(32)) bus ();
    id_decode_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        bus.if_valid = v;
        bus.if_inst  = inst;
        bus.if_pc    = pc;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;
        drive(1'b1, 32'h00500093, 32'h100);
        step;
        step;
        vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_id_valid: got %b want 0", bus.id_valid); end
        vectors++; if (bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL reset_if_ready: got %b want 1", bus.if_ready); end
        vectors++; if (bus.id_SextOpe !== 5'b0) begin miscompares++; $display("FAIL reset_sext: got %b want 00000", bus.id_SextOpe); end
        vectors++; if (bus.id_imm !== 25'h0 || bus.id_pc !== 32'h0 || bus.id_illegal !== 1'b0) begin miscompares++; $display("FAIL reset_payload: imm %h pc %h ill %b want 0", bus.id_imm, bus.id_pc, bus.id_illegal); end
        rst_n = 1'b1;
        step;
        vectors++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h100) begin miscompares++; $display("FAIL reset_first: valid %b pc %h want 1 00000100", bus.id_valid, bus.id_pc); end
        drive(1'b0, 32'h0, 32'h0);
        step;
        vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_drain: got %b want 0", bus.id_valid); end
    endtask

    task automatic test_stream;
        logic [31:0] insts [10] = '{32'h00500093, 32'h00112023, 32'hFE000EE3, 32'h008000EF, 32'h123450B7,
                                    32'h002081B3, 32'h00002103, 32'h000080E7, 32'h00000073, 32'h00001097};
        logic [4:0]  sexts [10] = '{IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, 5'b00000, IMM_I, IMM_I, IMM_I, IMM_U};
        logic [31:0] w;
        bus.ex_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            w = insts[i];
            drive(1'b1, w, 32'h1000 + 32'(i * 4));
            step;
            vectors++; if (bus.id_valid !== 1'b1 || bus.id_pc !== 32'h1000 + 32'(i * 4)) begin miscompares++; $display("FAIL stream_pc[%0d]: valid %b pc %h want 1 %h", i, bus.id_valid, bus.id_pc, 32'h1000 + 32'(i * 4)); end
            vectors++; if (bus.id_SextOpe !== sexts[i]) begin miscompares++; $display("FAIL stream_sext[%0d]: got %b want %b", i, bus.id_SextOpe, sexts[i]); end
            vectors++; if (bus.id_imm !== w[31:7] || bus.id_illegal !== 1'b0) begin miscompares++; $display("FAIL stream_imm[%0d]: imm %h ill %b want %h 0", i, bus.id_imm, bus.id_illegal, w[31:7]); end
            vectors++; if (bus.id_rs1 !== w[19:15] || bus.id_rs2 !== w[24:20] || bus.id_rd !== w[11:7] || bus.id_opcode !== w[6:0]) begin miscompares++; $display("FAIL stream_fields[%0d]: rs1 %h rs2 %h rd %h op %h", i, bus.id_rs1, bus.id_rs2, bus.id_rd, bus.id_opcode); end
        end
        drive(1'b0, 32'h0, 32'h0);
        step;
        vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain: got %b want 0", bus.id_valid); end
    endtask

    task automatic test_stall;
        bus.ex_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h200);
        step;
        vectors++; if (bus.id_pc !== 32'h200 || bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL stall_one: pc %h rdy %b want 00000200 1", bus.id_pc, bus.if_ready); end
        drive(1'b1, 32'h00200093, 32'h204);
        step;
        vectors++; if (bus.if_ready !== 1'b0 || bus.id_pc !== 32'h200) begin miscompares++; $display("FAIL stall_full: rdy %b pc %h want 0 00000200", bus.if_ready, bus.id_pc); end
        drive(1'b1, 32'h00300093, 32'h208);
        step;
        step;
        vectors++; if (bus.if_ready !== 1'b0 || bus.id_pc !== 32'h200 || bus.id_valid !== 1'b1) begin miscompares++; $display("FAIL stall_hold: rdy %b pc %h valid %b want 0 00000200 1", bus.if_ready, bus.id_pc, bus.id_valid); end
        bus.ex_ready = 1'b1;
        step;
        vectors++; if (bus.id_pc !== 32'h204 || bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL stall_second: pc %h rdy %b want 00000204 1", bus.id_pc, bus.if_ready); end
        step;
        vectors++; if (bus.id_pc !== 32'h208 || bus.id_valid !== 1'b1) begin miscompares++; $display("FAIL stall_third: pc %h valid %b want 00000208 1", bus.id_pc, bus.id_valid); end
        drive(1'b0, 32'h0, 32'h0);
        step;
        vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain: got %b want 0", bus.id_valid); end
    endtask

    task automatic test_flush;
        bus.ex_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h300);
        step;
        drive(1'b1, 32'h00200093, 32'h304);
        step;
        drive(1'b1, 32'h00300093, 32'h308);
        bus.flush = 1'b1;
        step;
        vectors++; if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL flush_full: valid %b rdy %b want 0 1", bus.id_valid, bus.if_ready); end
        bus.flush = 1'b0;
        drive(1'b1, 32'h00400093, 32'h30C);
        step;
        drive(1'b1, 32'h00500093, 32'h310);
        bus.flush = 1'b1;
        step;
        vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL flush_one_discard: valid %b want 0", bus.id_valid); end
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step;
        vectors++; if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL flush_after: valid %b rdy %b want 0 1", bus.id_valid, bus.if_ready); end
    endtask

    task automatic test_illegal;
        bus.ex_ready = 1'b1;
        drive(1'b1, 32'h0000007F, 32'h400);
        step;
        vectors++; if (bus.id_valid !== 1'b1 || bus.id_illegal !== 1'b1) begin miscompares++; $display("FAIL illegal_flag: valid %b ill %b want 1 1", bus.id_valid, bus.id_illegal); end
        vectors++; if (bus.id_SextOpe !== 5'b0 || bus.id_opcode !== 7'h7F) begin miscompares++; $display("FAIL illegal_sext: sext %b op %h want 00000 7f", bus.id_SextOpe, bus.id_opcode); end
        drive(1'b0, 32'h0, 32'h0);
        step;
    endtask

    task automatic test_reset_full;
        bus.ex_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h500);
        step;
        drive(1'b1, 32'hFE000EE3, 32'h504);
        step;
        vectors++; if (bus.if_ready !== 1'b0) begin miscompares++; $display("FAIL rstfull_setup: rdy %b want 0", bus.if_ready); end
        rst_n = 1'b0;
        bus.flush = 1'b1;
        step;
        vectors++; if (bus.id_valid !== 1'b0 || bus.if_ready !== 1'b1) begin miscompares++; $display("FAIL rstfull_state: valid %b rdy %b want 0 1", bus.id_valid, bus.if_ready); end
        vectors++; if (bus.id_pc !== 32'h0 || bus.id_imm !== 25'h0 || bus.id_SextOpe !== 5'b0 || bus.id_illegal !== 1'b0 || bus.id_opcode !== 7'h0) begin miscompares++; $display("FAIL rstfull_payload: pc %h imm %h sext %b ill %b op %h want 0", bus.id_pc, bus.id_imm, bus.id_SextOpe, bus.id_illegal, bus.id_opcode); end
        rst_n = 1'b1;
        bus.flush = 1'b0;
        bus.ex_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0);
        step;
        vectors++; if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL rstfull_skid_gone: valid %b want 0", bus.id_valid); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset;
        test_stream;
        test_stall;
        test_flush;
        test_illegal;
        test_reset_full;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
